// File: rtl/nes_mem_pkg.sv
// rtl/nes_mem_pkg.sv - shared encodings for the memory request arbiter
package nes_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        PORT_PPU = 2'd0,
        PORT_CPU = 2'd1,
        PORT_LD  = 2'd2
    } port_id_e;

    localparam logic [3:0] REGION_PRGROM = 4'b0000;
    localparam logic [3:0] REGION_CHRROM = 4'b1000;
    localparam logic [3:0] REGION_VRAM   = 4'b1100;
    localparam logic [3:0] REGION_RAM    = 4'b1110;
    localparam logic [3:0] REGION_PRGRAM = 4'b1111;

    // Region prefix of a 22-bit controller address
    function automatic logic [3:0] addr_region(input logic [21:0] addr);
        return addr[21:18];
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - arbiter to memory controller strobe bus
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8
);
    logic              mc_read_a;
    logic              mc_read_b;
    logic              mc_write;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_din;
    logic              mc_busy;
    logic [DATA_W-1:0] mc_dout_a;
    logic [DATA_W-1:0] mc_dout_b;

    modport master (
        output mc_read_a, mc_read_b, mc_write, mc_addr, mc_din,
        input  mc_busy, mc_dout_a, mc_dout_b
    );

    modport slave (
        input  mc_read_a, mc_read_b, mc_write, mc_addr, mc_din,
        output mc_busy, mc_dout_a, mc_dout_b
    );
endinterface

// File: rtl/mem_req_slot.sv
// rtl/mem_req_slot.sv - one pending request slot with overrun detection
module mem_req_slot #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_din,
    input  logic              grant,
    output logic              valid,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    output logic              overrun
);
    logic              pending_q, pending_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;

    // An incoming strobe is visible the same cycle so an idle arbiter can grant it without a slot hop
    assign valid = pending_q | req;
    assign we    = pending_q ? we_q   : req_we;
    assign addr  = pending_q ? addr_q : req_addr;
    assign din   = pending_q ? din_q  : req_din;

    // Latch, drop or bypass the incoming strobe depending on occupancy and grant
    always_comb begin
        pending_d = pending_q & ~grant;
        we_d      = we_q;
        addr_d    = addr_q;
        din_d     = din_q;
        overrun   = 1'b0;
        if (req) begin
            if (pending_q && !grant) begin
                overrun = 1'b1;
            end else if (pending_q || !grant) begin
                pending_d = 1'b1;
                we_d      = req_we;
                addr_d    = req_addr;
                din_d     = req_din;
            end
        end
    end

    // Slot state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            pending_q <= pending_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
        end
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - three-port request arbiter in front of the memory controller
module mem_req_arbiter
    import nes_mem_pkg::*;
#(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 8,
    parameter bit CPU_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_ack,
    output logic [DATA_W-1:0] ppu_dout,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_din,
    output logic              ld_ack,
    output logic              overrun,
    mem_req_arbiter_if.master mc
);
    logic [2:0]        slot_valid;
    logic [2:0]        slot_we;
    logic [2:0]        slot_ovr;
    logic [2:0]        grant_oh;
    logic [ADDR_W-1:0] slot_addr [0:2];
    logic [DATA_W-1:0] slot_din  [0:2];
    port_id_e          grant_id;
    logic              do_grant;

    arb_state_e        state_q, state_d;
    port_id_e          cur_port_q, cur_port_d;
    logic              cur_we_q, cur_we_d;
    logic              read_a_q, read_a_d;
    logic              read_b_q, read_b_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
    logic [DATA_W-1:0] mc_din_q, mc_din_d;
    logic              ppu_ack_q, ppu_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ld_ack_q, ld_ack_d;
    logic [DATA_W-1:0] ppu_dout_q, ppu_dout_d;
    logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
    logic              overrun_q, overrun_d;

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_ppu (
        .clk(clk), .reset(reset), .req(ppu_req), .req_we(1'b0), .req_addr(ppu_addr),
        .req_din('0), .grant(grant_oh[PORT_PPU]), .valid(slot_valid[PORT_PPU]),
        .we(slot_we[PORT_PPU]), .addr(slot_addr[PORT_PPU]), .din(slot_din[PORT_PPU]),
        .overrun(slot_ovr[PORT_PPU])
    );

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_cpu (
        .clk(clk), .reset(reset), .req(cpu_req), .req_we(cpu_we), .req_addr(cpu_addr),
        .req_din(cpu_din), .grant(grant_oh[PORT_CPU]), .valid(slot_valid[PORT_CPU]),
        .we(slot_we[PORT_CPU]), .addr(slot_addr[PORT_CPU]), .din(slot_din[PORT_CPU]),
        .overrun(slot_ovr[PORT_CPU])
    );

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_ld (
        .clk(clk), .reset(reset), .req(ld_req), .req_we(1'b1), .req_addr(ld_addr),
        .req_din(ld_din), .grant(grant_oh[PORT_LD]), .valid(slot_valid[PORT_LD]),
        .we(slot_we[PORT_LD]), .addr(slot_addr[PORT_LD]), .din(slot_din[PORT_LD]),
        .overrun(slot_ovr[PORT_LD])
    );

    // Fixed-priority encoder; the loader only wins when nobody else is asking
    always_comb begin
        grant_id = PORT_LD;
        if (CPU_FIRST) begin
            if (slot_valid[PORT_CPU])      grant_id = PORT_CPU;
            else if (slot_valid[PORT_PPU]) grant_id = PORT_PPU;
        end else begin
            if (slot_valid[PORT_PPU])      grant_id = PORT_PPU;
            else if (slot_valid[PORT_CPU]) grant_id = PORT_CPU;
        end
    end

    // Access sequencer: grant, one-cycle strobe, wait for the controller, then complete
    always_comb begin
        state_d    = state_q;
        cur_port_d = cur_port_q;
        cur_we_d   = cur_we_q;
        read_a_d   = 1'b0;
        read_b_d   = 1'b0;
        write_d    = 1'b0;
        mc_addr_d  = mc_addr_q;
        mc_din_d   = mc_din_q;
        ppu_ack_d  = 1'b0;
        cpu_ack_d  = 1'b0;
        ld_ack_d   = 1'b0;
        ppu_dout_d = ppu_dout_q;
        cpu_dout_d = cpu_dout_q;
        overrun_d  = overrun_q | (|slot_ovr);
        grant_oh   = 3'b000;
        do_grant   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Waiting on mc_busy here also covers a controller still finishing an aborted access
                if (!mc.mc_busy && (|slot_valid)) do_grant = 1'b1;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mc.mc_busy) begin
                    state_d = ST_IDLE;
                    case (cur_port_q)
                        PORT_PPU: begin
                            ppu_ack_d  = 1'b1;
                            ppu_dout_d = mc.mc_dout_b;
                        end
                        PORT_CPU: begin
                            cpu_ack_d = 1'b1;
                            if (!cur_we_q) cpu_dout_d = mc.mc_dout_a;
                        end
                        default: ld_ack_d = 1'b1;
                    endcase
                    if (|slot_valid) do_grant = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_grant) begin
            state_d            = ST_ISSUE;
            grant_oh[grant_id] = 1'b1;
            cur_port_d         = grant_id;
            cur_we_d           = slot_we[grant_id];
            mc_addr_d          = slot_addr[grant_id];
            mc_din_d           = slot_din[grant_id];
            case (grant_id)
                PORT_PPU: read_b_d = 1'b1;
                PORT_CPU: begin
                    if (slot_we[PORT_CPU]) write_d  = 1'b1;
                    else                   read_a_d = 1'b1;
                end
                default: write_d = 1'b1;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_port_q <= PORT_PPU;
            cur_we_q   <= 1'b0;
            read_a_q   <= 1'b0;
            read_b_q   <= 1'b0;
            write_q    <= 1'b0;
            mc_addr_q  <= '0;
            mc_din_q   <= '0;
            ppu_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            ld_ack_q   <= 1'b0;
            ppu_dout_q <= '0;
            cpu_dout_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_port_q <= cur_port_d;
            cur_we_q   <= cur_we_d;
            read_a_q   <= read_a_d;
            read_b_q   <= read_b_d;
            write_q    <= write_d;
            mc_addr_q  <= mc_addr_d;
            mc_din_q   <= mc_din_d;
            ppu_ack_q  <= ppu_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            ld_ack_q   <= ld_ack_d;
            ppu_dout_q <= ppu_dout_d;
            cpu_dout_q <= cpu_dout_d;
            overrun_q  <= overrun_d;
        end
    end

    assign mc.mc_read_a = read_a_q;
    assign mc.mc_read_b = read_b_q;
    assign mc.mc_write  = write_q;
    assign mc.mc_addr   = mc_addr_q;
    assign mc.mc_din    = mc_din_q;
    assign ppu_ack      = ppu_ack_q;
    assign cpu_ack      = cpu_ack_q;
    assign ld_ack       = ld_ack_q;
    assign ppu_dout     = ppu_dout_q;
    assign cpu_dout     = cpu_dout_q;
    assign overrun      = overrun_q;
endmodule
